// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and round helpers for the iterative compression core.
package sha1_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned STATE_W    = 5 * WORD_W;
  localparam int unsigned WIN_WORDS  = 16;
  localparam int unsigned BLOCK_W    = WIN_WORDS * WORD_W;
  localparam int unsigned NUM_ROUNDS = 80;
  localparam int unsigned CNT_W      = 7;

  localparam logic [STATE_W-1:0] SHA1_IV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  localparam logic [WORD_W-1:0] K_0_19  = 32'h5A827999;
  localparam logic [WORD_W-1:0] K_20_39 = 32'h6ED9EBA1;
  localparam logic [WORD_W-1:0] K_40_59 = 32'h8F1BBCDC;
  localparam logic [WORD_W-1:0] K_60_79 = 32'hCA62C1D6;

  // Field order puts A in the most significant word, matching {A,B,C,D,E} buses.
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
  } sha1_state_t;

  typedef enum logic [1:0] {
    F_CH     = 2'd0,
    F_PARITY = 2'd1,
    F_MAJ    = 2'd2
  } f_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  function automatic f_sel_t f_select(input logic [CNT_W-1:0] t);
    if (t < CNT_W'(20))      return F_CH;
    else if (t < CNT_W'(40)) return F_PARITY;
    else if (t < CNT_W'(60)) return F_MAJ;
    else                     return F_PARITY;
  endfunction

  function automatic logic [WORD_W-1:0] k_select(input logic [CNT_W-1:0] t);
    if (t < CNT_W'(20))      return K_0_19;
    else if (t < CNT_W'(40)) return K_20_39;
    else if (t < CNT_W'(60)) return K_40_59;
    else                     return K_60_79;
  endfunction

  function automatic logic [WORD_W-1:0] rotl1(input logic [WORD_W-1:0] x);
    return {x[WORD_W-2:0], x[WORD_W-1]};
  endfunction

  function automatic logic [WORD_W-1:0] rotl5(input logic [WORD_W-1:0] x);
    return {x[WORD_W-6:0], x[WORD_W-1:WORD_W-5]};
  endfunction

  function automatic logic [WORD_W-1:0] rotl30(input logic [WORD_W-1:0] x);
    return {x[1:0], x[WORD_W-1:2]};
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: state, schedule word and round index in, next state out.
module sha1_round
  import sha1_pkg::*;
(
  input  sha1_state_t        i_state,
  input  logic [WORD_W-1:0]  i_w,
  input  logic [CNT_W-1:0]   i_t,
  output sha1_state_t        o_state_c
);

  logic [WORD_W-1:0] w_f;
  logic [WORD_W-1:0] w_temp;

  always_comb begin
    w_f       = '0;
    w_temp    = '0;
    o_state_c = '0;
    case (f_select(i_t))
      F_CH:    w_f = (i_state.b & i_state.c) | (~i_state.b & i_state.d);
      F_MAJ:   w_f = (i_state.b & i_state.c) | (i_state.b & i_state.d) |
                     (i_state.c & i_state.d);
      default: w_f = i_state.b ^ i_state.c ^ i_state.d;
    endcase
    w_temp      = rotl5(i_state.a) + w_f + i_state.e + k_select(i_t) + i_w;
    o_state_c.a = w_temp;
    o_state_c.b = i_state.a;
    o_state_c.c = rotl30(i_state.b);
    o_state_c.d = i_state.c;
    o_state_c.e = i_state.d;
  end

endmodule

// File: rtl/sha1_iter_core.sv
// Iterative SHA-1 compression engine: RPC rounds per clock over a sliding 16-word
// message schedule window, with optional chaining add and a one-cycle done pulse.
module sha1_iter_core
  import sha1_pkg::*;
#(
  parameter int unsigned RPC    = 1,
  parameter bit          ADD_IV = 1'b0
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] msg,
  input  logic [STATE_W-1:0] initial_status,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] hash
);

  localparam int unsigned EXT_WORDS = WIN_WORDS + RPC;

  if (RPC == 0 || RPC > 20 || (NUM_ROUNDS % RPC) != 0) begin : g_bad_rpc
    $error("sha1_iter_core: RPC must be a divisor of 80 no larger than 20");
  end

  fsm_state_t         r_state;
  fsm_state_t         w_state_nxt;
  sha1_state_t        r_st;
  sha1_state_t        r_iv;
  sha1_state_t        w_final;
  logic [WORD_W-1:0]  r_win     [WIN_WORDS];
  logic [WORD_W-1:0]  w_win_nxt [WIN_WORDS];
  logic [WORD_W-1:0]  w_rw      [RPC];
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               r_done;
  logic [STATE_W-1:0] r_hash;
  logic [STATE_W-1:0] w_result;
  logic               w_load;
  logic               w_step;
  logic               w_finish;

  assign w_cnt_nxt = r_cnt + CNT_W'(RPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath controls.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_cnt_nxt == CNT_W'(NUM_ROUNDS)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Extend the window by RPC words so rounds beyond the window (RPC > 16) see fresh words.
  always_comb begin
    logic [WORD_W-1:0] ext [EXT_WORDS];
    for (int i = 0; i < int'(WIN_WORDS); i++) ext[i] = r_win[i];
    for (int i = int'(WIN_WORDS); i < int'(EXT_WORDS); i++)
      ext[i] = rotl1(ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16]);
    for (int j = 0; j < int'(RPC); j++) w_rw[j] = ext[j];
    for (int i = 0; i < int'(WIN_WORDS); i++) w_win_nxt[i] = ext[i+int'(RPC)];
  end

  for (genvar j = 0; j < int'(RPC); j++) begin : g_rnd
    sha1_state_t w_in;
    sha1_state_t w_out;
    if (j == 0) begin : g_first
      assign w_in = r_st;
    end else begin : g_next
      assign w_in = g_rnd[j-1].w_out;
    end
    sha1_round u_round (
      .i_state   (w_in),
      .i_w       (w_rw[j]),
      .i_t       (r_cnt + CNT_W'(j)),
      .o_state_c (w_out)
    );
  end

  assign w_final = g_rnd[RPC-1].w_out;

  always_comb begin
    w_result = w_final;
    if (ADD_IV) begin
      w_result = {w_final.a + r_iv.a, w_final.b + r_iv.b, w_final.c + r_iv.c,
                  w_final.d + r_iv.d, w_final.e + r_iv.e};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st   <= '0;
      r_iv   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hash <= '0;
      for (int i = 0; i < int'(WIN_WORDS); i++) r_win[i] <= '0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= w_finish;
      if (w_load) begin
        r_st  <= initial_status;
        r_iv  <= initial_status;
        r_cnt <= '0;
        for (int i = 0; i < int'(WIN_WORDS); i++) r_win[i] <= msg[i*WORD_W +: WORD_W];
      end else if (w_step) begin
        r_st  <= w_final;
        r_cnt <= w_cnt_nxt;
        for (int i = 0; i < int'(WIN_WORDS); i++) r_win[i] <= w_win_nxt[i];
      end
      if (w_finish) r_hash <= w_result;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hash = r_hash;

endmodule

// File: tb/tb_sha1_iter_core.sv
// Bench for sha1_iter_core: three configurations checked against a plain SHA-1 model.
module tb_sha1_iter_core;

  localparam int NDUT = 3;
  localparam logic [159:0] IV0 = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_v [NDUT];
  logic [511:0] msg_v   [NDUT];
  logic [159:0] iv_v    [NDUT];
  logic         busy_v  [NDUT];
  logic         done_v  [NDUT];
  logic [159:0] hash_v  [NDUT];
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  sha1_iter_core #(.RPC(1), .ADD_IV(1'b0)) u_dut_r1 (
    .clk(clk), .reset(rst), .start(start_v[0]), .msg(msg_v[0]),
    .initial_status(iv_v[0]), .busy(busy_v[0]), .done(done_v[0]), .hash(hash_v[0]));
  sha1_iter_core #(.RPC(5), .ADD_IV(1'b1)) u_dut_r5 (
    .clk(clk), .reset(rst), .start(start_v[1]), .msg(msg_v[1]),
    .initial_status(iv_v[1]), .busy(busy_v[1]), .done(done_v[1]), .hash(hash_v[1]));
  sha1_iter_core #(.RPC(20), .ADD_IV(1'b1)) u_dut_r20 (
    .clk(clk), .reset(rst), .start(start_v[2]), .msg(msg_v[2]),
    .initial_status(iv_v[2]), .busy(busy_v[2]), .done(done_v[2]), .hash(hash_v[2]));

  function automatic int rpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 5;
      default: return 20;
    endcase
  endfunction

  function automatic bit add_of(input int k);
    return k != 0;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook SHA-1 compression of one block.
  function automatic logic [159:0] ref_sha1(input logic [511:0] m, input logic [159:0] iv,
                                            input bit add);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = m[32*t +: 32];
    for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    {a, b, c, d, e} = iv;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rol(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    if (add) begin
      a += iv[159:128]; b += iv[127:96]; c += iv[95:64]; d += iv[63:32]; e += iv[31:0];
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [511:0] msg_hello();
    logic [511:0] m = '0;
    m[31:0]    = 32'h68656C6C;
    m[63:32]   = 32'h6F20776F;
    m[95:64]   = 32'h726C6480;
    m[511:480] = 32'h00000058;
    return m;
  endfunction

  function automatic logic [511:0] msg_abc();
    logic [511:0] m = '0;
    m[31:0]    = 32'h61626380;
    m[511:480] = 32'h00000018;
    return m;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [159:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one block; lat counts edges from the accepting edge (1) to the done edge.
  task automatic run_block(input int k, input logic [511:0] m, input logic [159:0] iv,
                           output logic [159:0] h, output int lat);
    @(negedge clk);
    start_v[k] = 1'b1; msg_v[k] = m; iv_v[k] = iv;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0; msg_v[k] = ~m; iv_v[k] = ~iv;
    lat = 1;
    check($sformatf("busy_after_accept_%0d", k), 160'(busy_v[k]), 160'(1));
    while (!done_v[k] && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done_v[k]) check($sformatf("done_timeout_%0d", k), 160'(done_v[k]), 160'(1));
    check($sformatf("busy_at_done_%0d", k), 160'(busy_v[k]), 160'(0));
    h = hash_v[k];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [159:0] h, h1, h2, hres, iv, exp;
    logic [511:0] m;
    int lat, edge_n, ndone, done_edge, e1, e2, bad;

    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      start_v[k] = 1'b0; msg_v[k] = '0; iv_v[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_busy_%0d", k), 160'(busy_v[k]), 160'(0));
      check($sformatf("rst_done_%0d", k), 160'(done_v[k]), 160'(0));
      check($sformatf("rst_hash_%0d", k), hash_v[k], 160'(0));
    end
    rst = 1'b0;

    // Known vectors.
    run_block(0, msg_hello(), IV0, h, lat);
    check("r1_hello_lat", 160'(lat), 160'(81));
    check("r1_hello_a", 160'(h[159:128]), 160'(32'hC3694934));
    check("r1_hello_model", h, ref_sha1(msg_hello(), IV0, 1'b0));
    run_block(1, msg_hello(), IV0, h, lat);
    check("r5_hello_lat", 160'(lat), 160'(17));
    check("r5_hello_digest", h, 160'h2AAE6C35C94FCFB415DBE95F408B9CE91EE846ED);
    run_block(2, msg_abc(), IV0, h, lat);
    check("r20_abc_lat", 160'(lat), 160'(5));
    check("r20_abc_digest", h, 160'hA9993E364706816ABA3E25717850C26C9CD0D89D);

    // Random blocks and chaining states.
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 4; n++) begin
        m  = rand_block();
        iv = ($urandom_range(0, 1) == 0) ? IV0 : rand_state();
        run_block(k, m, iv, h, lat);
        check($sformatf("rand_lat_%0d_%0d", k, n), 160'(lat), 160'(80 / rpc_of(k) + 1));
        check($sformatf("rand_hash_%0d_%0d", k, n), h, ref_sha1(m, iv, add_of(k)));
      end
    end

    // start re-pulsed while busy, inputs scrambled after accept.
    m   = rand_block();
    exp = ref_sha1(m, IV0, 1'b0);
    @(negedge clk);
    start_v[0] = 1'b1; msg_v[0] = m; iv_v[0] = IV0;
    @(posedge clk);
    edge_n = 1; ndone = 0; done_edge = 0; hres = '0;
    while (edge_n < 120) begin
      @(negedge clk);
      if (done_v[0]) begin ndone++; done_edge = edge_n; hres = hash_v[0]; end
      start_v[0] = (edge_n + 1 == 3) || (edge_n + 1 == 40);
      msg_v[0] = rand_block(); iv_v[0] = rand_state();
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
    start_v[0] = 1'b0;
    check("ignore_ndone", 160'(ndone), 160'(1));
    check("ignore_done_edge", 160'(done_edge), 160'(81));
    check("ignore_hash", hres, exp);

    // start held high across two blocks.
    @(negedge clk);
    start_v[1] = 1'b1; msg_v[1] = msg_abc(); iv_v[1] = IV0;
    @(posedge clk);
    edge_n = 1;
    @(negedge clk);
    msg_v[1] = msg_hello();
    ndone = 0; bad = 0; e1 = 0; e2 = 0; h1 = '0; h2 = '0;
    while (ndone < 2 && edge_n < 100) begin
      if (done_v[1]) begin
        if (ndone == 0) begin e1 = edge_n; h1 = hash_v[1]; end
        else begin e2 = edge_n; h2 = hash_v[1]; end
        ndone++;
        if (ndone == 2) start_v[1] = 1'b0;
      end else if (ndone == 1 && hash_v[1] !== h1) begin
        bad++;
      end
      @(posedge clk);
      edge_n++;
      @(negedge clk);
    end
    start_v[1] = 1'b0;
    check("hold_ndone", 160'(ndone), 160'(2));
    check("hold_first_edge", 160'(e1), 160'(17));
    check("hold_spacing", 160'(e2 - e1), 160'(17));
    check("hold_hash_abc", h1, ref_sha1(msg_abc(), IV0, 1'b1));
    check("hold_hash_hello", h2, ref_sha1(msg_hello(), IV0, 1'b1));
    check("hold_hash_stable", 160'(bad), 160'(0));

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start_v[0] = 1'b1; msg_v[0] = msg_abc(); iv_v[0] = IV0;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (29) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 160'(busy_v[0]), 160'(0));
    check("midrst_done", 160'(done_v[0]), 160'(0));
    check("midrst_hash", hash_v[0], 160'(0));
    check("midrst_hash_r5", hash_v[1], 160'(0));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0] || busy_v[0]) ndone++;
    end
    check("midrst_quiet", 160'(ndone), 160'(0));
    run_block(0, msg_abc(), IV0, h, lat);
    check("postrst_lat", 160'(lat), 160'(81));
    check("postrst_hash", h, ref_sha1(msg_abc(), IV0, 1'b0));
    check("postrst_hash_a", 160'(h[159:128] + 32'h67452301), 160'(32'hA9993E36));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
